edge_event_capture: RTL and testbench

- Consumes the single-bit registered stream produced by the sim-test flip-flop stage (its q) and converts it into timestamped edge events.
- Detects rising and falling transitions, stamps each with a free-running cycle counter, and buffers the events in a small FIFO.
- Events drain to downstream check logic through a valid/ready interface.
- Also keeps a saturating toggle count and a sticky overflow flag.

---
 rtl/edge_cap_pkg.sv | 29 ++
 rtl/edge_cap_fifo.sv | 109 ++++++++++
 rtl/edge_event_capture.sv | 168 ++++++++++++++++
 tb/tb_edge_event_capture.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_cap_pkg.sv
// -----------------------------------------------------------------------------
// edge_cap_pkg
// Shared definitions for the edge-event capture block: default sizes and the
// elaboration-time helpers used to size pointers and to validate DEPTH.
// The event record {pol, ts} depends on the TS_W parameter of its user, so
// it is declared as a typedef inside the parameterised top level.
// -----------------------------------------------------------------------------
package edge_cap_pkg;

    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 4;

    // Ceiling log2 usable in localparam expressions; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // The FIFO pointers rely on natural wrap, so DEPTH must be a power of two
    // and at least 2.
    function automatic bit depth_ok(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/edge_cap_fifo.sv
// -----------------------------------------------------------------------------
// edge_cap_fifo
// Synchronous FIFO holding captured edge events. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. The head entry is
// registered so it holds its last value while the FIFO is empty.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr_i     synchronous clear: empties the FIFO, blocks any push
//   push_i    write request for wdata_i
//   wdata_i   entry to write
//   pop_i     remove the head entry (ignored when empty)
//   accept_o  push_i was taken this cycle
//   full_o    occupancy == DEPTH
//   empty_o   occupancy == 0
//   head_o    current head entry (last value held when empty)
// -----------------------------------------------------------------------------
module edge_cap_fifo
    import edge_cap_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output logic accept_o,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remain;
    T                 head_q, head_d;
    T                 mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign accept_o = do_push && !clr_i;
    // Entries left after this cycle's pop, before this cycle's push.
    assign remain   = count_q - CNT_W'(do_pop);
    assign head_o   = head_q;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = remain + CNT_W'(do_push);
            // Next head: bypass the incoming entry when nothing else remains,
            // otherwise the stored entry at the advanced read pointer.
            if (count_d != '0) begin
                head_d = (remain == '0) ? wdata_i : mem_q[rd_ptr_d];
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable
    // through head_q, which is reset and only loaded from valid entries.
    always_ff @(posedge clk) begin
        if (accept_o) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/edge_event_capture.sv
// -----------------------------------------------------------------------------
// edge_event_capture
// Turns a registered single-bit stream into timestamped edge events. Rising
// and falling transitions (while en is high) are stamped with a free-running
// cycle counter and queued in a small FIFO drained over valid/ready. Also keeps
// a saturating count of accepted edges and a sticky overflow flag.
//
// Build option: define EDGE_CAPTURE_STUCK_DETECT_EN to add an idle counter,
// the STUCK_LIMIT parameter and the stuck output.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   d_in         sampled bit stream
//   en           edge-capture enable
//   clr          synchronous clear (highest priority in its cycle)
//   ev_valid     event available at FIFO head
//   ev_ready     consumer accepts the head event
//   ev_pol       head event polarity, 1 = rising
//   ev_ts        head event timestamp
//   ev_overflow  sticky: an event was dropped on a full FIFO
//   toggle_cnt   saturating count of accepted edges
//   stuck        (optional) no edge for STUCK_LIMIT enabled cycles
// -----------------------------------------------------------------------------
module edge_event_capture
    import edge_cap_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
`ifdef EDGE_CAPTURE_STUCK_DETECT_EN
   ,parameter int STUCK_LIMIT = 4
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d_in,
    input  logic            en,
    input  logic            clr,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic            ev_pol,
    output logic [TS_W-1:0] ev_ts,
    output logic            ev_overflow,
    output logic [TS_W-1:0] toggle_cnt
`ifdef EDGE_CAPTURE_STUCK_DETECT_EN
   ,output logic            stuck
`endif
);

    typedef struct packed {
        logic            pol;
        logic [TS_W-1:0] ts;
    } ev_t;

    localparam bit DEPTH_OK = depth_ok(DEPTH);

    logic            d_prev_q;
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0] toggle_q, toggle_d;
    logic            ovf_q, ovf_d;
    logic            edge_det;
    logic            push_req;
    logic            ev_pop;
    logic            drop;
    logic            accepted;
    logic            fifo_full;
    logic            fifo_empty;
    ev_t             wr_ev;
    ev_t             head_ev;

    // Edge against the previous sample; en gates detection, not sampling.
    assign edge_det = en && (d_in != d_prev_q);
    // clr discards any edge in its cycle.
    assign push_req = edge_det && !clr;
    assign ev_pop   = ev_valid && ev_ready;
    assign drop     = push_req && fifo_full && !ev_pop;

    assign wr_ev.pol = d_in;
    assign wr_ev.ts  = ts_cnt_q;

    edge_cap_fifo #(
        .DEPTH (DEPTH),
        .T     (ev_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr),
        .push_i   (push_req),
        .wdata_i  (wr_ev),
        .pop_i    (ev_pop),
        .accept_o (accepted),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (head_ev)
    );

    assign ev_valid    = !fifo_empty;
    assign ev_pol      = head_ev.pol;
    assign ev_ts       = head_ev.ts;
    assign ev_overflow = ovf_q;
    assign toggle_cnt  = toggle_q;

    always_comb begin
        ts_cnt_d = ts_cnt_q + TS_W'(1);
        toggle_d = toggle_q;
        ovf_d    = ovf_q;
        if (clr) begin
            ts_cnt_d = '0;
            toggle_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (accepted && (toggle_q != '1)) begin
                toggle_d = toggle_q + TS_W'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev_q <= 1'b0;
            ts_cnt_q <= '0;
            toggle_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            d_prev_q <= d_in;
            ts_cnt_q <= ts_cnt_d;
            toggle_q <= toggle_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef EDGE_CAPTURE_STUCK_DETECT_EN
    localparam int IDLE_W = clog2(STUCK_LIMIT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Counts enabled cycles without an edge; en low freezes it.
    always_comb begin
        idle_d = idle_q;
        if (clr) begin
            idle_d = '0;
        end else if (en) begin
            if (edge_det) begin
                idle_d = '0;
            end else if (idle_q != IDLE_W'(STUCK_LIMIT)) begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign stuck = en && (idle_q == IDLE_W'(STUCK_LIMIT));
`endif

    // DEPTH must be a power of two >= 2 for the wrapping pointers.
    a_depth_ok : assert property (@(posedge clk) DEPTH_OK);

endmodule

// File: tb/tb_edge_event_capture.sv
// -----------------------------------------------------------------------------
// tb_edge_event_capture
// Self-checking bench for edge_event_capture (TS_W=8, DEPTH=4). Inputs are
// driven on the falling edge; a scoreboard queue holds the events the bench
// expects the DUT to emit and is compared whenever the head is valid. Table
// rows add per-cycle expectations for ev_valid, toggle_cnt and ev_overflow.
// Define EDGE_CAPTURE_STUCK_DETECT_EN for both bench and RTL to cover stuck.
// -----------------------------------------------------------------------------
module tb_edge_event_capture;

    localparam int TS_W  = 8;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst_n;
    logic            d_in;
    logic            en;
    logic            clr;
    logic            ev_valid;
    logic            ev_ready;
    logic            ev_pol;
    logic [TS_W-1:0] ev_ts;
    logic            ev_overflow;
    logic [TS_W-1:0] toggle_cnt;
`ifdef EDGE_CAPTURE_STUCK_DETECT_EN
    logic            stuck;
`endif

    edge_event_capture #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_in        (d_in),
        .en          (en),
        .clr         (clr),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_pol      (ev_pol),
        .ev_ts       (ev_ts),
        .ev_overflow (ev_overflow),
        .toggle_cnt  (toggle_cnt)
`ifdef EDGE_CAPTURE_STUCK_DETECT_EN
       ,.stuck       (stuck)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            pol;
        logic [TS_W-1:0] ts;
    } exp_ev_t;

    typedef struct {
        logic            d;
        logic            e;
        logic            r;
        logic            c;
        logic            exp_valid;
        logic [TS_W-1:0] exp_tog;
        logic            exp_ovf;
    } vec_t;

    exp_ev_t         sb[$];
    vec_t            vecs[$];
    logic [TS_W-1:0] m_ts;
    logic            m_prev;
    int              n_vec;
    int              n_miscmp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left on a falling edge. Checks the head
    // against the scoreboard, then predicts what the coming rising edge does.
    task automatic cycle(input logic d, input logic e, input logic r, input logic c);
        exp_ev_t ev;
        d_in     = d;
        en       = e;
        ev_ready = r;
        clr      = c;
        #1;
        check("ev_valid_sb", ev_valid, sb.size() != 0);
        if (ev_valid && sb.size() != 0) begin
            check("head_pol", ev_pol, sb[0].pol);
            check("head_ts", ev_ts, sb[0].ts);
        end
        if (c) begin
            sb.delete();
            m_ts = '0;
        end else begin
            if (sb.size() != 0 && r) begin
                void'(sb.pop_front());
            end
            if (e && (d != m_prev) && sb.size() < DEPTH) begin
                ev.pol = d;
                ev.ts  = m_ts;
                sb.push_back(ev);
            end
            m_ts = m_ts + 1'b1;
        end
        m_prev = d;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected self-termination");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        rst_n    = 1'b0;
        d_in     = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        ev_ready = 1'b0;
        m_ts     = '0;
        m_prev   = 1'b0;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        check("rst_valid", ev_valid, 0);
        check("rst_pol", ev_pol, 0);
        check("rst_ts", ev_ts, 0);
        check("rst_ovf", ev_overflow, 0);
        check("rst_tog", toggle_cnt, 0);
`ifdef EDGE_CAPTURE_STUCK_DETECT_EN
        check("rst_stuck", stuck, 0);
`endif
        rst_n = 1'b1;

        // ---------------- table: d, en, rdy, clr -> valid, toggle_cnt, overflow
        // toggle every clock with the consumer ready
        vecs.push_back('{1, 1, 1, 0, 1, 8'd1, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 8'd2, 0});
        vecs.push_back('{1, 1, 1, 0, 1, 8'd3, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 8'd4, 0});
        vecs.push_back('{1, 1, 1, 0, 1, 8'd5, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 8'd6, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 8'd6, 0});
        // six toggles into a stalled consumer: four kept, two dropped
        vecs.push_back('{1, 1, 0, 0, 1, 8'd7, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 8'd8, 0});
        vecs.push_back('{1, 1, 0, 0, 1, 8'd9, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 8'd10, 0});
        vecs.push_back('{1, 1, 0, 0, 1, 8'd10, 1});
        vecs.push_back('{0, 1, 0, 0, 1, 8'd10, 1});
        // drain exactly four
        vecs.push_back('{0, 1, 1, 0, 1, 8'd10, 1});
        vecs.push_back('{0, 1, 1, 0, 1, 8'd10, 1});
        vecs.push_back('{0, 1, 1, 0, 1, 8'd10, 1});
        vecs.push_back('{0, 1, 1, 0, 0, 8'd10, 1});
        // clr wipes counters and the sticky flag
        vecs.push_back('{0, 1, 0, 1, 0, 8'd0, 0});
        // fill to full, then edge with pop in the same cycle
        vecs.push_back('{1, 1, 0, 0, 1, 8'd1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 8'd2, 0});
        vecs.push_back('{1, 1, 0, 0, 1, 8'd3, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 8'd4, 0});
        vecs.push_back('{1, 1, 1, 0, 1, 8'd5, 0});
        vecs.push_back('{1, 1, 1, 0, 1, 8'd5, 0});
        vecs.push_back('{1, 1, 1, 0, 1, 8'd5, 0});
        vecs.push_back('{1, 1, 1, 0, 1, 8'd5, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 8'd5, 0});
        // edges while disabled, then enable with a stable input
        vecs.push_back('{0, 0, 1, 0, 0, 8'd5, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 8'd5, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 8'd5, 0});

        foreach (vecs[i]) begin
            cycle(vecs[i].d, vecs[i].e, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d_valid", i), ev_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_tog", i), toggle_cnt, vecs[i].exp_tog);
            check($sformatf("vec%0d_ovf", i), ev_overflow, vecs[i].exp_ovf);
        end

        // ---------------- clr in the same cycle as an edge, two events queued
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check("pre_clr_tog", toggle_cnt, 7);
        cycle(0, 1, 0, 1);
        check("clr_valid", ev_valid, 0);
        check("clr_tog", toggle_cnt, 0);
        check("clr_ovf", ev_overflow, 0);
        cycle(1, 1, 0, 0);
        check("post_clr_valid", ev_valid, 1);
        check("post_clr_pol", ev_pol, 1);
        check("post_clr_ts", ev_ts, 0);
        check("post_clr_tog", toggle_cnt, 1);
        cycle(1, 1, 1, 0);
        check("post_clr_drained", ev_valid, 0);

`ifdef EDGE_CAPTURE_STUCK_DETECT_EN
        // ---------------- stuck after STUCK_LIMIT idle enabled cycles
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        check("stuck_3idle", stuck, 0);
        cycle(0, 1, 1, 0);
        check("stuck_4idle", stuck, 1);
        cycle(1, 1, 1, 0);
        check("stuck_after_edge", stuck, 0);
`else
        cycle(1, 1, 1, 0);
`endif

        // ---------------- reset asserted mid-drain
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 1, 0);
        check("pre_rst_valid", ev_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", ev_valid, 0);
        check("midrst_pol", ev_pol, 0);
        check("midrst_ts", ev_ts, 0);
        check("midrst_ovf", ev_overflow, 0);
        check("midrst_tog", toggle_cnt, 0);
        sb.delete();
        m_ts   = '0;
        m_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // d_in stays high: first edge is measured against d_prev = 0
        cycle(1, 1, 1, 0);
        check("rst_first_valid", ev_valid, 1);
        check("rst_first_pol", ev_pol, 1);
        check("rst_first_ts", ev_ts, 0);
        cycle(1, 1, 1, 0);
        check("rst_drained", ev_valid, 0);
        cycle(1, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
